// File: rtl/memory_stage_pkg.sv
// Shared control-field indices, handshake FSM encoding and defaults for the MEM stage.
package memory_stage_pkg;

  localparam int MEM_READ_BIT   = 0;
  localparam int MEM_WRITE_BIT  = 1;
  localparam int BRANCH_NE_BIT  = 2;
  localparam int IS_BRANCH_BIT  = 3;

  localparam int MEM_TO_REG_BIT = 0;
  localparam int REG_WRITE_BIT  = 1;

  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } hs_state_e;

  function automatic logic is_misaligned(input logic mem_op, input logic [1:0] addr_lsb);
    return mem_op && (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/memory_stage_dcache_handshake.sv
// Data-cache request/ready handshake: drives the request, holds the pipeline while
// waiting, and abandons an access that exceeds the timeout.
module dcache_handshake
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic access,
  input  logic is_write,
  input  logic dc_ready,
  output logic dc_req,
  output logic dc_we,
  output logic cache_stall,
  output logic xfer_done,
  output logic timeout_hit
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

  hs_state_e       state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d, cnt_inc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + TW'(1);
    dc_req      = 1'b0;
    dc_we       = 1'b0;
    cache_stall = 1'b0;
    xfer_done   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (access) begin
          dc_req = 1'b1;
          dc_we  = is_write;
          if (dc_ready) begin
            xfer_done = 1'b1;
          end else begin
            state_d     = ST_WAIT;
            cache_stall = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        dc_req = 1'b1;
        dc_we  = is_write;
        // A late ready on the final allowed cycle still wins over the timeout.
        if (dc_ready) begin
          xfer_done = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else if (cnt_inc == LIMIT) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = '0;
        end else begin
          cache_stall = 1'b1;
          cnt_d       = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (reset) begin
      dc_req      = 1'b0;
      dc_we       = 1'b0;
      cache_stall = 1'b0;
      xfer_done   = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: data-cache access, branch resolution, MEM/WB registers and bypass sources.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ALU_OUT,
  input  logic [31:0]      RT_DATA,
  input  logic [4:0]       WRITE_REG,
  input  logic [3:0]       MEM_CTRL,
  input  logic [1:0]       WB_CTRL,
  input  logic             prediction,
  input  logic [31:0]      RECOVER_TAKEN,
  input  logic [31:0]      RECOVER_NOT_TAKEN,
  output logic             DC_REQ,
  output logic             DC_WE,
  output logic [31:0]      DC_ADDR,
  output logic [31:0]      DC_WDATA,
  input  logic             DC_READY,
  input  logic [31:0]      DC_RDATA,
  output logic             cache_stall,
  output logic             flush,
  output logic [31:0]      REDIRECT_PC,
  output logic [31:0]      MEM_DATA,
  output logic [31:0]      REG_ALU_OUT,
  output logic [31:0]      REG_READ_DATA,
  output logic [4:0]       REG_WRITE_REG,
  output logic [1:0]       REG_WB_CTRL,
  output logic [31:0]      WB_DATA,
  output logic             ALIGN_ERR,
  output logic             BUS_ERR,
  output logic [CNT_W-1:0] STALL_CYCLES
);

  logic mem_op, misaligned, access, is_branch, taken;
  logic xfer_done, timeout_hit;

  logic [31:0]      reg_alu_out_q, reg_alu_out_d;
  logic [31:0]      reg_read_data_q, reg_read_data_d;
  logic [4:0]       reg_write_reg_q, reg_write_reg_d;
  logic [1:0]       reg_wb_ctrl_q, reg_wb_ctrl_d;
  logic             align_err_q, align_err_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign mem_op     = MEM_CTRL[MEM_READ_BIT] | MEM_CTRL[MEM_WRITE_BIT];
  assign misaligned = is_misaligned(mem_op, ALU_OUT[1:0]);
  assign access     = mem_op & ~misaligned;

  dcache_handshake #(.TIMEOUT(TIMEOUT)) u_hs (
    .clk         (clk),
    .reset       (reset),
    .access      (access),
    .is_write    (MEM_CTRL[MEM_WRITE_BIT]),
    .dc_ready    (DC_READY),
    .dc_req      (DC_REQ),
    .dc_we       (DC_WE),
    .cache_stall (cache_stall),
    .xfer_done   (xfer_done),
    .timeout_hit (timeout_hit)
  );

  assign DC_ADDR  = ALU_OUT;
  assign DC_WDATA = RT_DATA;
  assign MEM_DATA = ALU_OUT;

  // A memory op sharing an encoding with a branch suppresses the flush.
  assign is_branch   = MEM_CTRL[IS_BRANCH_BIT];
  assign taken       = is_branch & ((ALU_OUT == 32'd0) ^ MEM_CTRL[BRANCH_NE_BIT]);
  assign flush       = ~reset & is_branch & ~mem_op & (taken != prediction);
  assign REDIRECT_PC = taken ? RECOVER_TAKEN : RECOVER_NOT_TAKEN;

  always_comb begin
    reg_alu_out_d   = reg_alu_out_q;
    reg_read_data_d = reg_read_data_q;
    reg_write_reg_d = reg_write_reg_q;
    reg_wb_ctrl_d   = reg_wb_ctrl_q;
    if (!cache_stall) begin
      reg_alu_out_d   = ALU_OUT;
      reg_write_reg_d = WRITE_REG;
      reg_wb_ctrl_d   = WB_CTRL;
      reg_read_data_d = (xfer_done && MEM_CTRL[MEM_READ_BIT]) ? DC_RDATA : 32'd0;
    end
    align_err_d = align_err_q | misaligned;
    bus_err_d   = bus_err_q | timeout_hit;
    stall_cnt_d = stall_cnt_q;
    if (cache_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_alu_out_q   <= '0;
      reg_read_data_q <= '0;
      reg_write_reg_q <= '0;
      reg_wb_ctrl_q   <= '0;
      align_err_q     <= 1'b0;
      bus_err_q       <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      reg_alu_out_q   <= reg_alu_out_d;
      reg_read_data_q <= reg_read_data_d;
      reg_write_reg_q <= reg_write_reg_d;
      reg_wb_ctrl_q   <= reg_wb_ctrl_d;
      align_err_q     <= align_err_d;
      bus_err_q       <= bus_err_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign REG_ALU_OUT   = reg_alu_out_q;
  assign REG_READ_DATA = reg_read_data_q;
  assign REG_WRITE_REG = reg_write_reg_q;
  assign REG_WB_CTRL   = reg_wb_ctrl_q;
  assign WB_DATA       = reg_wb_ctrl_q[MEM_TO_REG_BIT] ? reg_read_data_q : reg_alu_out_q;
  assign ALIGN_ERR     = align_err_q;
  assign BUS_ERR       = bus_err_q;
  assign STALL_CYCLES  = stall_cnt_q;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized scoreboard bench for memory_stage against a transaction-level reference model.
module tb_memory_stage;

  localparam int T     = 8;
  localparam int CNT_W = 6;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] ALU_OUT, RT_DATA, RECOVER_TAKEN, RECOVER_NOT_TAKEN, DC_RDATA;
  logic [4:0]  WRITE_REG;
  logic [3:0]  MEM_CTRL;
  logic [1:0]  WB_CTRL;
  logic        prediction, DC_READY;
  logic        DC_REQ, DC_WE, cache_stall, flush, ALIGN_ERR, BUS_ERR;
  logic [31:0] DC_ADDR, DC_WDATA, REDIRECT_PC, MEM_DATA, REG_ALU_OUT, REG_READ_DATA, WB_DATA;
  logic [4:0]  REG_WRITE_REG;
  logic [1:0]  REG_WB_CTRL;
  logic [CNT_W-1:0] STALL_CYCLES;

  memory_stage #(.TIMEOUT(T), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ALU_OUT(ALU_OUT), .RT_DATA(RT_DATA), .WRITE_REG(WRITE_REG),
    .MEM_CTRL(MEM_CTRL), .WB_CTRL(WB_CTRL), .prediction(prediction),
    .RECOVER_TAKEN(RECOVER_TAKEN), .RECOVER_NOT_TAKEN(RECOVER_NOT_TAKEN),
    .DC_REQ(DC_REQ), .DC_WE(DC_WE), .DC_ADDR(DC_ADDR), .DC_WDATA(DC_WDATA),
    .DC_READY(DC_READY), .DC_RDATA(DC_RDATA), .cache_stall(cache_stall), .flush(flush),
    .REDIRECT_PC(REDIRECT_PC), .MEM_DATA(MEM_DATA), .REG_ALU_OUT(REG_ALU_OUT),
    .REG_READ_DATA(REG_READ_DATA), .REG_WRITE_REG(REG_WRITE_REG), .REG_WB_CTRL(REG_WB_CTRL),
    .WB_DATA(WB_DATA), .ALIGN_ERR(ALIGN_ERR), .BUS_ERR(BUS_ERR), .STALL_CYCLES(STALL_CYCLES)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, rt, rtk, rnt, rdata;
    logic [4:0]  wreg;
    logic [3:0]  mctrl;
    logic [1:0]  wbctrl;
    logic        pred;
    int          lat;
  } txn_t;

  typedef struct {
    logic [31:0] alu, rd;
    logic [4:0]  wreg;
    logic [1:0]  wbctrl;
  } wb_t;

  wb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  logic m_align, m_bus;
  int   m_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    ALU_OUT = 0; RT_DATA = 0; WRITE_REG = 0; MEM_CTRL = 0; WB_CTRL = 0; prediction = 0;
    RECOVER_TAKEN = 0; RECOVER_NOT_TAKEN = 0; DC_READY = 0; DC_RDATA = 0;
  endtask

  task automatic model_reset();
    m_align = 0; m_bus = 0; m_stall = 0;
  endtask

  // Issue one EX/MEM instruction, hold it until it commits, and check cycle-level controls.
  task automatic run_txn(input txn_t t);
    logic memop, aligned, access, br, taken, exp_flush;
    int   last;
    wb_t  e;
    memop   = t.mctrl[0] | t.mctrl[1];
    aligned = (t.alu[1:0] == 2'b00);
    access  = memop & aligned;
    last    = access ? ((t.lat < T - 1) ? t.lat : T - 1) : 0;
    br      = t.mctrl[3];
    taken   = br && ((t.alu == 0) != t.mctrl[2]);
    exp_flush = br && !memop && (taken != t.pred);
    e.alu    = t.alu;
    e.wreg   = t.wreg;
    e.wbctrl = t.wbctrl;
    e.rd     = (access && t.mctrl[0] && t.lat <= T - 1) ? t.rdata : 32'd0;
    sb.push_back(e);
    ALU_OUT = t.alu; RT_DATA = t.rt; WRITE_REG = t.wreg; MEM_CTRL = t.mctrl;
    WB_CTRL = t.wbctrl; prediction = t.pred; RECOVER_TAKEN = t.rtk;
    RECOVER_NOT_TAKEN = t.rnt; DC_RDATA = t.rdata;
    for (int k = 0; k <= last; k++) begin
      DC_READY = access ? (k == t.lat) : 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("dc_req", DC_REQ, access);
      chk("cache_stall", cache_stall, access && (k < last));
      chk("flush", flush, exp_flush);
      if (access) chk("dc_we", DC_WE, t.mctrl[1]);
      if (br && k == 0) chk("redirect_pc", REDIRECT_PC, taken ? t.rtk : t.rnt);
      if (k == 0) chk("dc_addr", DC_ADDR, t.alu);
      @(posedge clk); #1;
    end
    if (memop && !aligned) m_align = 1;
    if (access && t.lat > T - 1) m_bus = 1;
    if (access) m_stall = (m_stall + last > SAT) ? SAT : m_stall + last;
    chk("align_err", ALIGN_ERR, m_align);
    chk("bus_err", BUS_ERR, m_bus);
    chk("stall_cycles", STALL_CYCLES, m_stall);
  endtask

  function automatic txn_t mk(input logic [31:0] alu, input logic [3:0] mctrl,
                              input logic [1:0] wbctrl, input logic pred, input int lat);
    txn_t t;
    t.alu = alu; t.mctrl = mctrl; t.wbctrl = wbctrl; t.pred = pred; t.lat = lat;
    t.rt = $urandom; t.rtk = $urandom; t.rnt = $urandom; t.rdata = $urandom;
    t.wreg = 5'($urandom_range(0, 31));
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int kind, r;
    logic [31:0] a;
    kind = $urandom_range(0, 3);
    a = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    r = $urandom_range(0, 9);
    t = mk(a, 4'b0000, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
    if (r >= 4 && r <= 7) t.lat = $urandom_range(1, 5);
    else if (r == 8)      t.lat = $urandom_range(6, 7);
    else if (r == 9)      t.lat = $urandom_range(8, 12);
    case (kind)
      1: t.mctrl = 4'b0001;
      2: t.mctrl = 4'b0010;
      3: begin
        t.mctrl = {1'b1, 1'($urandom_range(0, 1)), 2'b00};
        if ($urandom_range(0, 1) == 1) t.alu = 32'd0;
      end
      default: t.mctrl = 4'b0000;
    endcase
    return t;
  endfunction

  // Monitor: any edge with cache_stall low outside reset is a MEM/WB commit.
  initial begin
    logic c;
    wb_t  e;
    forever begin
      @(negedge clk);
      c = !cache_stall && !reset;
      @(posedge clk); #1;
      if (c) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_commit actual=1 expected=0 at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("reg_alu_out", REG_ALU_OUT, e.alu);
          chk("reg_read_data", REG_READ_DATA, e.rd);
          chk("reg_write_reg", REG_WRITE_REG, e.wreg);
          chk("reg_wb_ctrl", REG_WB_CTRL, e.wbctrl);
          chk("wb_data", WB_DATA, e.wbctrl[0] ? e.rd : e.alu);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    drive_idle();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg_alu", REG_ALU_OUT, 0);
    chk("rst_reg_rd", REG_READ_DATA, 0);
    chk("rst_reg_wreg", REG_WRITE_REG, 0);
    chk("rst_reg_wbctrl", REG_WB_CTRL, 0);
    chk("rst_stall_cnt", STALL_CYCLES, 0);
    chk("rst_errs", {ALIGN_ERR, BUS_ERR}, 0);
    reset = 0;

    t = mk(32'h100, 4'b0001, 2'b11, 0, 0); t.rdata = 32'hDEADBEEF;
    run_txn(t);                                        // load hit
    run_txn(mk(32'h200, 4'b0010, 2'b00, 0, 3));        // store miss, 3 stalls
    t = mk(32'h0, 4'b1000, 2'b00, 0, 0); t.rtk = 32'h4000; t.rnt = 32'h0104;
    run_txn(t);                                        // taken, predicted not
    t.pred = 1;
    run_txn(t);                                        // taken, predicted taken
    run_txn(mk(32'h5, 4'b1100, 2'b00, 1, 0));          // bne taken, correct
    run_txn(mk(32'h0, 4'b1001, 2'b11, 0, 0));          // branch+load: mem_op wins
    run_txn(mk(32'h102, 4'b0001, 2'b11, 0, 0));        // misaligned load
    run_txn(mk(32'h300, 4'b0001, 2'b01, 0, 7));        // ready on last allowed cycle
    run_txn(mk(32'h400, 4'b0001, 2'b01, 0, 1000));     // timeout

    // Reset in the second WAIT cycle abandons the access.
    ALU_OUT = 32'h500; MEM_CTRL = 4'b0001; WB_CTRL = 2'b11; WRITE_REG = 5'd7; DC_READY = 0;
    @(negedge clk); chk("rw_stall_c0", cache_stall, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("rw_dc_req", DC_REQ, 0);
    chk("rw_stall", cache_stall, 0);
    chk("rw_flush", flush, 0);
    @(posedge clk); #1;
    chk("rw_reg_alu", REG_ALU_OUT, 0);
    chk("rw_reg_wreg", REG_WRITE_REG, 0);
    chk("rw_reg_wbctrl", REG_WB_CTRL, 0);
    reset = 0;
    model_reset();
    run_txn(mk(32'h600, 4'b0001, 2'b01, 0, 0));        // IDLE again: hit, no stall

    for (int i = 0; i < 250; i++) run_txn(rand_txn());
    for (int i = 0; i < 10; i++) run_txn(mk(32'h700, 4'b0010, 2'b00, 0, 50)); // saturate

    drive_idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
